// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
// The receiver drives the word, its status flags and the idle indication; the consumer drives ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rxDataOUT;
    logic                 rxValidOUT;
    logic                 rxReadyIN;
    logic                 rxParityErrOUT;
    logic                 rxFrameErrOUT;
    logic                 rxBreakOUT;
    logic                 rxOverrunOUT;
    logic                 rxIdleOUT;

    modport master (
        output rxDataOUT,
        output rxValidOUT,
        input  rxReadyIN,
        output rxParityErrOUT,
        output rxFrameErrOUT,
        output rxBreakOUT,
        output rxOverrunOUT,
        output rxIdleOUT
    );

    modport slave (
        input  rxDataOUT,
        input  rxValidOUT,
        output rxReadyIN,
        input  rxParityErrOUT,
        input  rxFrameErrOUT,
        input  rxBreakOUT,
        input  rxOverrunOUT,
        input  rxIdleOUT
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: synchroniser + majority filter, 16x oversampling FSM,
// single-entry output holding register with parity/frame/break/overrun status.
module uart_rx_param #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic            clockIN,
    input  logic            rxResetNIN,
    input  logic            rxIN,
    uart_rx_param_if.master rx_bus
);
    localparam int DIV_RAW = CLOCK_FREQUENCY / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]           sync_q, sync_d;
    logic [2:0]           filt_q, filt_d;
    logic                 line;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;

    state_t               state_q, state_d;
    logic [3:0]           sub_q, sub_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 wait_high_q, wait_high_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 first_stop_q, first_stop_d;
    logic                 sample;
    logic                 last_stop;

    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;
    logic                 handshake;
    logic                 first_stop_now;
    logic                 new_perr;
    logic                 new_ferr;
    logic                 new_brk;

    // Line conditioning and free-running oversample tick
    always_comb begin
        sync_d = {sync_q[0], rxIN};
        filt_d = {filt_q[1:0], sync_q[1]};
        line   = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
        tick   = (div_q == DIV_W'(DIV - 1));
        div_d  = tick ? '0 : div_q + DIV_W'(1);
    end

    // Frame decoder: start validation at mid-bit, then one sample every 16 ticks
    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        wait_high_d  = wait_high_q;
        frame_err_d  = frame_err_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        first_stop_d = first_stop_q;
        last_stop    = 1'b0;
        sample       = tick && (sub_q == 4'd15);

        case (state_q)
            S_IDLE: begin
                if (line) begin
                    wait_high_d = 1'b0;
                end
                if (tick && !line && !wait_high_q) begin
                    state_d = S_START;
                    sub_d   = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sub_q == 4'd7) begin
                        sub_d = 4'd0;
                        if (!line) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                end
                if (sample) begin
                    shift_d   = {line, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d     = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_cnt_d  = 1'b0;
                        frame_err_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                end
                if (sample) begin
                    par_bit_d = line;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                end
                if (sample) begin
                    stop_cnt_d  = stop_cnt_q + 1'b1;
                    frame_err_d = frame_err_q | ~line;
                    if (stop_cnt_q == 1'b0) begin
                        first_stop_d = line;
                    end
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        last_stop   = 1'b1;
                        state_d     = S_IDLE;
                        sub_d       = 4'd0;
                        // A low stop bit may be a break: hold off restarts until the line idles.
                        wait_high_d = frame_err_q | ~line;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output holding register and consumer handshake
    always_comb begin
        data_out_d     = data_out_q;
        valid_d        = valid_q;
        perr_d         = perr_q;
        ferr_d         = ferr_q;
        brk_d          = brk_q;
        ovr_d          = ovr_q;
        handshake      = valid_q & rx_bus.rxReadyIN;
        first_stop_now = (stop_cnt_q == 1'b0) ? line : first_stop_q;
        new_ferr       = frame_err_q | ~line;
        new_perr       = (PARITY == 1) ? ~(^shift_q ^ par_bit_q) :
                         (PARITY == 2) ?  (^shift_q ^ par_bit_q) : 1'b0;
        new_brk        = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !first_stop_now;

        if (last_stop && (!valid_q || handshake)) begin
            data_out_d = shift_q;
            perr_d     = new_perr;
            ferr_d     = new_ferr;
            brk_d      = new_brk;
            valid_d    = 1'b1;
            ovr_d      = 1'b0;
        end else if (last_stop) begin
            ovr_d = 1'b1;
        end else if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clockIN) begin
        if (!rxResetNIN) begin
            sync_q      <= '1;
            filt_q      <= '1;
            div_q       <= '0;
            state_q     <= S_IDLE;
            sub_q       <= 4'd0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            wait_high_q <= 1'b0;
            frame_err_q <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            div_q       <= div_d;
            state_q     <= state_d;
            sub_q       <= sub_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            wait_high_q <= wait_high_d;
            frame_err_q <= frame_err_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
        end
    end

    always_ff @(posedge clockIN) begin
        shift_q      <= shift_d;
        par_bit_q    <= par_bit_d;
        first_stop_q <= first_stop_d;
    end

    assign rx_bus.rxDataOUT      = data_out_q;
    assign rx_bus.rxValidOUT     = valid_q;
    assign rx_bus.rxParityErrOUT = perr_q;
    assign rx_bus.rxFrameErrOUT  = ferr_q;
    assign rx_bus.rxBreakOUT     = brk_q;
    assign rx_bus.rxOverrunOUT   = ovr_q;
    assign rx_bus.rxIdleOUT      = (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 8N2) at 16 clocks per bit,
// directed frames plus random frames checked against a frame-level reference model.
module tb_uart_rx_param;
    localparam int CF  = 16_000_000;
    localparam int BR  = 1_000_000;
    localparam int BIT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_line [3];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   vcyc_n1      = 0;
    word_t got_n1 [$];
    word_t got_e1 [$];
    word_t got_n2 [$];

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus_n1 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_e1 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_n2 ();

    uart_rx_param #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_n1 (.clockIN(clk), .rxResetNIN(rst_n), .rxIN(rx_line[0]), .rx_bus(bus_n1));
    uart_rx_param #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_e1 (.clockIN(clk), .rxResetNIN(rst_n), .rxIN(rx_line[1]), .rx_bus(bus_e1));
    uart_rx_param #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        dut_n2 (.clockIN(clk), .rxResetNIN(rst_n), .rxIN(rx_line[2]), .rx_bus(bus_n2));

    // Capture every accepted word and count cycles with a word on offer.
    always @(negedge clk) begin
        if (bus_n1.rxValidOUT) vcyc_n1 <= vcyc_n1 + 1;
        if (bus_n1.rxValidOUT && bus_n1.rxReadyIN)
            got_n1.push_back({bus_n1.rxDataOUT, bus_n1.rxParityErrOUT, bus_n1.rxFrameErrOUT, bus_n1.rxBreakOUT});
        if (bus_e1.rxValidOUT && bus_e1.rxReadyIN)
            got_e1.push_back({bus_e1.rxDataOUT, bus_e1.rxParityErrOUT, bus_e1.rxFrameErrOUT, bus_e1.rxBreakOUT});
        if (bus_n2.rxValidOUT && bus_n2.rxReadyIN)
            got_n2.push_back({bus_n2.rxDataOUT, bus_n2.rxParityErrOUT, bus_n2.rxFrameErrOUT, bus_n2.rxBreakOUT});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int ch, input logic b);
        rx_line[ch] = b;
        idle_clks(BIT);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input int pmode, input logic pbit,
                              input logic [1:0] stops, input int nstop);
        drive_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(ch, d[i]);
        if (pmode != 0) drive_bit(ch, pbit);
        for (int s = 0; s < nstop; s++) drive_bit(ch, stops[s]);
        rx_line[ch] = 1'b1;
    endtask

    // What a correct receiver must report for one frame, from the line contents alone.
    function automatic word_t model(input logic [7:0] d, input int pmode, input logic pbit,
                                    input logic [1:0] stops, input int nstop);
        word_t w;
        int    ones;
        ones   = $countones(d) + int'(pbit);
        w.data = d;
        w.perr = (pmode == 1) ? ((ones % 2) == 0) : (pmode == 2) ? ((ones % 2) == 1) : 1'b0;
        w.ferr = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
        w.brk  = (d == 8'h00) && ((pmode == 0) || (pbit == 1'b0)) && (stops[0] == 1'b0);
        return w;
    endfunction

    task automatic expect_word(input int ch, input word_t exp, input string tag);
        word_t w;
        int    n;
        case (ch)
            0:       n = got_n1.size();
            1:       n = got_e1.size();
            default: n = got_n2.size();
        endcase
        check({tag, "_count"}, n, 1);
        if (n > 0) begin
            case (ch)
                0:       w = got_n1.pop_front();
                1:       w = got_e1.pop_front();
                default: w = got_n2.pop_front();
            endcase
            check({tag, "_word"}, 32'(w), 32'(exp));
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       pb;
        logic [1:0] st;
        int         v0;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
        bus_n1.rxReadyIN = 1'b1;
        bus_e1.rxReadyIN = 1'b1;
        bus_n2.rxReadyIN = 1'b1;
        idle_clks(5);

        check("rst_data",  bus_n1.rxDataOUT, 0);
        check("rst_valid", bus_n1.rxValidOUT, 0);
        check("rst_perr",  bus_n1.rxParityErrOUT, 0);
        check("rst_ferr",  bus_n1.rxFrameErrOUT, 0);
        check("rst_brk",   bus_n1.rxBreakOUT, 0);
        check("rst_ovr",   bus_n1.rxOverrunOUT, 0);
        check("rst_idle",  bus_n1.rxIdleOUT, 1);
        check("rst_idle_e1", bus_e1.rxIdleOUT, 1);
        check("rst_idle_n2", bus_n2.rxIdleOUT, 1);
        rst_n = 1'b1;
        idle_clks(2 * BIT);

        // 8N1 basic word, valid for a single cycle with ready high
        v0 = vcyc_n1;
        send_frame(0, 8'hA5, 0, 1'b0, 2'b11, 1);
        idle_clks(2 * BIT);
        expect_word(0, model(8'hA5, 0, 1'b0, 2'b11, 1), "n1_a5");
        check("n1_a5_valid_cycles", vcyc_n1 - v0, 1);

        // 8E1 parity error and clean parity
        send_frame(1, 8'h03, 2, 1'b1, 2'b11, 1);
        idle_clks(2 * BIT);
        expect_word(1, '{data: 8'h03, perr: 1'b1, ferr: 1'b0, brk: 1'b0}, "e1_03_bad");
        send_frame(1, 8'h03, 2, 1'b0, 2'b11, 1);
        idle_clks(2 * BIT);
        expect_word(1, '{data: 8'h03, perr: 1'b0, ferr: 1'b0, brk: 1'b0}, "e1_03_good");

        // False start: short low pulse
        v0 = vcyc_n1;
        rx_line[0] = 1'b0;
        idle_clks(6);
        rx_line[0] = 1'b1;
        idle_clks(2);
        check("glitch_idle_low", bus_n1.rxIdleOUT, 0);
        idle_clks(2 * BIT);
        check("glitch_idle_back", bus_n1.rxIdleOUT, 1);
        check("glitch_no_valid", vcyc_n1 - v0, 0);
        check("glitch_no_word", got_n1.size(), 0);

        // 8N2: second stop low, then a long break
        send_frame(2, 8'h5C, 0, 1'b0, 2'b01, 2);
        idle_clks(2 * BIT);
        expect_word(2, '{data: 8'h5C, perr: 1'b0, ferr: 1'b1, brk: 1'b0}, "n2_stop2_low");
        rx_line[2] = 1'b0;
        idle_clks(20 * BIT);
        rx_line[2] = 1'b1;
        idle_clks(3 * BIT);
        expect_word(2, '{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1}, "n2_break");
        check("n2_break_single", got_n2.size(), 0);

        // Overrun: consumer stalled across two frames
        bus_n1.rxReadyIN = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 2'b11, 1);
        idle_clks(BIT);
        check("ovr_first_valid", bus_n1.rxValidOUT, 1);
        check("ovr_first_flag", bus_n1.rxOverrunOUT, 0);
        send_frame(0, 8'h22, 0, 1'b0, 2'b11, 1);
        idle_clks(2 * BIT);
        check("ovr_hold_data", bus_n1.rxDataOUT, 8'h11);
        check("ovr_hold_valid", bus_n1.rxValidOUT, 1);
        check("ovr_set", bus_n1.rxOverrunOUT, 1);
        bus_n1.rxReadyIN = 1'b1;
        idle_clks(1);
        check("ovr_clr_valid", bus_n1.rxValidOUT, 0);
        check("ovr_clr_flag", bus_n1.rxOverrunOUT, 0);
        expect_word(0, model(8'h11, 0, 1'b0, 2'b11, 1), "ovr_accepted");
        check("ovr_dropped", got_n1.size(), 0);

        // Reset during data bit 4 of 0x5A
        d = 8'h5A;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        rx_line[0] = d[4];
        idle_clks(BIT / 2);
        rst_n = 1'b0;
        idle_clks(BIT / 2);
        for (int i = 5; i < 8; i++) drive_bit(0, d[i]);
        drive_bit(0, 1'b1);
        idle_clks(BIT);
        check("midrst_idle", bus_n1.rxIdleOUT, 1);
        check("midrst_valid", bus_n1.rxValidOUT, 0);
        rst_n = 1'b1;
        idle_clks(2 * BIT);
        check("midrst_no_word", got_n1.size(), 0);
        check("midrst_no_valid", bus_n1.rxValidOUT, 0);
        send_frame(0, 8'h3C, 0, 1'b0, 2'b11, 1);
        idle_clks(2 * BIT);
        expect_word(0, model(8'h3C, 0, 1'b0, 2'b11, 1), "after_rst_3c");

        // Random frames on 8E1 and 8N1
        for (int k = 0; k < 16; k++) begin
            d  = (k % 5 == 0) ? 8'h00 : 8'($urandom);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            st = {1'b1, ($urandom_range(0, 4) != 0)};
            send_frame(1, d, 2, pb, st, 1);
            idle_clks(BIT * $urandom_range(1, 3));
            expect_word(1, model(d, 2, pb, st, 1), "rand_e1");

            d  = 8'($urandom);
            st = {1'b1, ($urandom_range(0, 4) != 0)};
            send_frame(0, d, 0, 1'b0, st, 1);
            idle_clks(BIT * $urandom_range(1, 3));
            expect_word(0, model(d, 0, 1'b0, st, 1), "rand_n1");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50_000_000, input clock in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9, LSB first on line.
REQ-004 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal 1..2.
REQ-006 Port clockIN  input  1  sole clock; all logic on its rising edge.
REQ-007 Port rxResetNIN  input  1  reset, synchronous, active-low.
REQ-008 Port rxIN  input  1  asynchronous serial line, idle high.
REQ-009 Port rxDataOUT  output  DATA_BITS  received word, bit 0 = first data bit.
REQ-010 Port rxValidOUT  output  1  rxDataOUT and error flags hold a word.
REQ-011 Port rxReadyIN  input  1  consumer accepts word when high with rxValidOUT.
REQ-012 Port rxParityErrOUT  output  1  parity mismatch for held word.
REQ-013 Port rxFrameErrOUT  output  1  a stop bit sampled low for held word.
REQ-014 Port rxBreakOUT  output  1  held word all-zero, parity (if any) zero, first stop bit zero.
REQ-015 Port rxOverrunOUT  output  1  sticky: at least one frame dropped since last handshake.
REQ-016 Port rxIdleOUT  output  1  receiver FSM in IDLE.

Function
REQ-017 rxIN SHALL pass a 2-flop synchroniser then a 3-sample majority filter; all decoding uses the filtered signal.
REQ-018 A 16x oversample tick SHALL pulse one clock every DIV = max(1, CLOCK_FREQUENCY/(BAUD_RATE*16)) clocks (integer division), free-running.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY = 0.
REQ-020 IDLE -> START on filtered line low at a tick; sub-tick counter cleared to 0.
REQ-021 START: at sub-count 7 line low -> DATA with sub-count cleared; line high -> IDLE (false start, no output, no flags).
REQ-022 DATA/PARITY/STOP: each bit sampled when sub-count reaches 15, i.e. 16 ticks after the previous sample; sub-count wraps to 0.
REQ-023 DATA collects exactly DATA_BITS samples shifted LSB first, then PARITY or STOP.
REQ-024 Parity error SHALL be set when XOR(data, parity bit) is 0 for odd or 1 for even.
REQ-025 STOP samples STOP_BITS bits; frame error if any is low; after last stop sample -> IDLE the next clock.
REQ-026 At last stop sample, if rxValidOUT is low or (rxValidOUT & rxReadyIN) in the same clock, word and flags SHALL load and rxValidOUT assert the next clock.
REQ-027 If rxValidOUT high and rxReadyIN low at last stop sample, new frame SHALL be dropped, held word unchanged, rxOverrunOUT set.
REQ-028 Handshake (rxValidOUT & rxReadyIN) SHALL clear rxValidOUT and rxOverrunOUT next clock unless a new word loads in that clock (REQ-026), in which case rxValidOUT stays high and rxOverrunOUT clears.
REQ-029 rxDataOUT and error flags SHALL be stable while rxValidOUT high and not accepted.
REQ-030 After a frame error FSM SHALL return to IDLE and wait for line high before accepting a new start (no restart on held-low break).
REQ-031 rxIdleOUT SHALL be 1 exactly when FSM is IDLE.

Reset
REQ-032 While rxResetNIN low at a clock edge: FSM -> IDLE, counters 0, synchroniser/filter preset to 1.
REQ-033 Reset values: rxDataOUT 0, rxValidOUT 0, all error flags 0, rxOverrunOUT 0, rxIdleOUT 1.
REQ-034 Reset mid-frame SHALL abandon the frame with no output; reception restarts only on a new start edge after release.

Verification (CLOCK_FREQUENCY 16_000_000, BAUD_RATE 1_000_000, bit = 16 clocks unless stated)
REQ-035 8N1, send 0xA5, rxReadyIN high -> rxDataOUT 0xA5, rxValidOUT one clock, no errors.
REQ-036 8E1, send 0x03 with parity bit 1 -> rxDataOUT 0x03, rxParityErrOUT 1; with parity bit 0 -> no error.
REQ-037 Line low for 6 clocks then high -> no rxValidOUT, rxIdleOUT back to 1.
REQ-038 8N2, second stop bit low -> rxFrameErrOUT 1; line low 20 bit-times -> rxDataOUT 0x00, rxBreakOUT 1, rxFrameErrOUT 1, single word only.
REQ-039 rxReadyIN low, send 0x11 then 0x22 -> rxDataOUT stays 0x11, rxOverrunOUT 1; raise rxReadyIN -> both clear next clock.
REQ-040 Assert rxResetNIN low at data bit 4 of 0x5A -> no output; next frame 0x3C received correctly.
